// File: rtl/rv_pkg.sv
// Shared types and widths for the register-file write side.
package rv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LD
    } wb_src_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests; head is visible combinationally from registered state.
module wb_fifo
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  wb_req_t din,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    wb_req_t       mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU and buffered load results onto the register-file write port and tracks outstanding loads.
module regfile_writeback #(
    parameter int unsigned LD_DEPTH = 2,
    parameter int unsigned XLEN     = rv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    output logic [31:0]     busy,
    output logic            stall_req,
    output logic [4:0]      wa,
    output logic            we,
    output logic [XLEN-1:0] wd
);

    import rv_pkg::*;

    localparam int unsigned PW = rv_pkg::XLEN;

    wb_req_t         ld_req;
    wb_req_t         fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;
    wb_src_e         sel;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [31:0]     busy_d;

    assign ld_ready    = !fifo_full;
    assign stall_req   = fifo_full;
    assign fifo_push   = ld_valid && ld_ready;
    assign ld_req.rd   = ld_rd;
    assign ld_req.data = PW'(ld_data);

    wb_fifo #(
        .DEPTH (LD_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (ld_req),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ALU wins the port; the FIFO head drains only on ALU-idle cycles.
    always_comb begin
        sel      = WB_NONE;
        sel_rd   = '0;
        sel_data = '0;
        fifo_pop = 1'b0;
        busy_d   = busy;
        if (alu_valid) begin
            sel      = WB_ALU;
            sel_rd   = alu_rd;
            sel_data = alu_data;
        end else if (!fifo_empty) begin
            sel      = WB_LD;
            fifo_pop = 1'b1;
            sel_rd   = fifo_head.rd;
            sel_data = XLEN'(fifo_head.data);
        end
        // A new issue to the same register outranks the retiring load.
        if (fifo_pop) busy_d[fifo_head.rd] = 1'b0;
        if (iss_valid && (iss_rd != 5'd0)) busy_d[iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we   <= 1'b0;
            wa   <= '0;
            wd   <= '0;
            busy <= '0;
        end else begin
            we   <= (sel != WB_NONE) && (sel_rd != 5'd0);
            busy <= busy_d;
            if (sel != WB_NONE) begin
                wa <= sel_rd;
                wd <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: expected writes queued at stimulus time, checked as they appear.
module tb_regfile_writeback;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [4:0]  ld_rd = '0;
    logic [31:0] ld_data = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic [31:0] busy;
    logic        stall_req;
    logic [4:0]  wa;
    logic        we;
    logic [31:0] wd;

    int n_tests = 0;
    int n_fail  = 0;
    wb_req_t exp_q[$];

    regfile_writeback #(.LD_DEPTH(2), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .busy(busy), .stall_req(stall_req),
        .wa(wa), .we(we), .wd(wd)
    );

    always #5 clk = ~clk;

    // Every visible write must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && we) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_write: wa=%0d wd=%h with nothing expected", wa, wd);
            end else begin
                wb_req_t e;
                e = exp_q.pop_front();
                if (wa !== e.rd || wd !== e.data) begin
                    n_fail++;
                    $display("FAIL write_order: got wa=%0d wd=%h, want wa=%0d wd=%h", wa, wd, e.rd, e.data);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [4:0] rd, input logic [31:0] data);
        wb_req_t e;
        e.rd = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic check_drained(input string name);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drained: %0d writes outstanding, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        n_tests++;
        if (we !== 1'b0 || wa !== 5'd0 || wd !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_port: we=%b wa=%0d wd=%h, want 0/0/0", we, wa, wd);
        end
        n_tests++;
        if (busy !== 32'd0 || ld_ready !== 1'b1 || stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%h ld_ready=%b stall_req=%b, want 0/1/0", busy, ld_ready, stall_req);
        end
        next_cycle();
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        expect_write(5'd5, 32'hDEADBEEF);
        next_cycle();
        n_tests++;
        if (we !== 1'b1 || wa !== 5'd5 || wd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL alu_write: we=%b wa=%0d wd=%h, want 1/5/deadbeef", we, wa, wd);
        end
        alu_rd = 5'd0; alu_data = 32'h1;
        next_cycle();
        alu_valid = 1'b0;
        n_tests++;
        if (we !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_x0: we=%b, want 0", we);
        end
        next_cycle();
        next_cycle();
        check_drained("alu");
    endtask

    task automatic test_load_sb();
        iss_valid = 1'b1; iss_rd = 5'd7;
        next_cycle();
        iss_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (busy[7] !== 1'b1) begin
                n_fail++;
                $display("FAIL load_busy_set[%0d]: busy=%h, want bit7 set", i, busy);
            end
            if (i < 2) next_cycle();
        end
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h1234;
        n_tests++;
        if (ld_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_ready: ld_ready=%b, want 1", ld_ready);
        end
        expect_write(5'd7, 32'h1234);
        next_cycle();
        ld_valid = 1'b0;
        n_tests++;
        if (we !== 1'b0 || busy[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL load_no_bypass: we=%b busy=%h, want we=0 bit7 set", we, busy);
        end
        next_cycle();
        n_tests++;
        if (we !== 1'b1 || busy[7] !== 1'b0 || busy !== 32'd0) begin
            n_fail++;
            $display("FAIL load_clear: we=%b busy=%h, want we=1 busy=0", we, busy);
        end
        next_cycle();
        check_drained("load");
    endtask

    task automatic test_contention();
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h33;
        expect_write(5'd4, 32'h40);
        expect_write(5'd4, 32'h41);
        expect_write(5'd4, 32'h42);
        expect_write(5'd3, 32'h33);
        next_cycle();
        ld_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h40 + 32'(i);
            next_cycle();
            n_tests++;
            if (we !== 1'b1 || wa !== 5'd4) begin
                n_fail++;
                $display("FAIL contention_alu[%0d]: we=%b wa=%0d, want 1/4", i, we, wa);
            end
        end
        alu_valid = 1'b0;
        next_cycle();
        n_tests++;
        if (we !== 1'b1 || wa !== 5'd3 || wd !== 32'h33) begin
            n_fail++;
            $display("FAIL contention_load: we=%b wa=%0d wd=%h, want 1/3/33", we, wa, wd);
        end
        next_cycle();
        check_drained("contention");
    endtask

    task automatic test_fill();
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (ld_ready !== (i < 2) || stall_req !== (i >= 2)) begin
                n_fail++;
                $display("FAIL fill_flags[%0d]: ld_ready=%b stall_req=%b", i, ld_ready, stall_req);
            end
            alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h100 + 32'(i);
            expect_write(5'd1, 32'h100 + 32'(i));
            ld_valid = 1'b1; ld_rd = 5'(10 + i); ld_data = 32'hA10 + 32'(i);
            next_cycle();
        end
        n_tests++;
        if (ld_ready !== 1'b0 || stall_req !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_full: ld_ready=%b stall_req=%b, want 0/1", ld_ready, stall_req);
        end
        alu_valid = 1'b0; ld_valid = 1'b0;
        expect_write(5'd10, 32'hA10);
        expect_write(5'd11, 32'hA11);
        next_cycle();
        n_tests++;
        if (ld_ready !== 1'b1 || stall_req !== 1'b0 || wa !== 5'd10) begin
            n_fail++;
            $display("FAIL fill_release: ld_ready=%b stall_req=%b wa=%0d, want 1/0/10", ld_ready, stall_req, wa);
        end
        next_cycle();
        next_cycle();
        next_cycle();
        check_drained("fill");
    endtask

    task automatic test_collision();
        iss_valid = 1'b1; iss_rd = 5'd9;
        next_cycle();
        iss_valid = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
        expect_write(5'd9, 32'h99);
        next_cycle();
        ld_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd9;
        next_cycle();
        iss_valid = 1'b0;
        n_tests++;
        if (we !== 1'b1 || busy[9] !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_set_wins: we=%b busy=%h, want we=1 bit9 set", we, busy);
        end
        next_cycle();
        n_tests++;
        if (busy !== 32'h0000_0200) begin
            n_fail++;
            $display("FAIL collision_hold: busy=%h, want 00000200", busy);
        end
        check_drained("collision");
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        #2 rst = 1'b0;
        next_cycle();
        iss_valid = 1'b1; iss_rd = 5'd3;
        next_cycle();
        iss_rd = 5'd7;
        next_cycle();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hBAD;
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'hA3;
        next_cycle();
        ld_rd = 5'd7; ld_data = 32'hA7;
        next_cycle();
        ld_valid = 1'b0;
        n_tests++;
        if (busy !== 32'h0000_0088 || stall_req !== 1'b1 || ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_pre: busy=%h stall_req=%b ld_ready=%b, want 88/1/0", busy, stall_req, ld_ready);
        end
        #2 rst = 1'b1;
        alu_valid = 1'b0;
        #1;
        n_tests++;
        if (we !== 1'b0 || busy !== 32'd0 || ld_ready !== 1'b1 || stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: we=%b busy=%h ld_ready=%b stall_req=%b, want 0/0/1/0", we, busy, ld_ready, stall_req);
        end
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            n_tests++;
            if (we !== 1'b0 || busy !== 32'd0) begin
                n_fail++;
                $display("FAIL rstmid_stale[%0d]: we=%b wa=%0d busy=%h, want we=0 busy=0", i, we, wa, busy);
            end
        end
        check_drained("rstmid");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_sb();
        test_contention();
        test_fill();
        test_collision();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
